// File: rtl/hazard_scoreboard_ctrl.sv
// ============================================================================
//  Module   : hazard_scoreboard_ctrl
//  Brief    : Busy-timer scoreboard that stalls ID on RAW hazards and squashes
//             wrong-path work on a taken branch. Optional perf counters are
//             enabled by defining HAZARD_PERF_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard_ctrl #(
  parameter int NREG       = 4,
  parameter int TIMER_INIT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      ifid_ir,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [NREG-1:0]  busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int             c_TW   = $clog2(TIMER_INIT + 1);
  localparam logic [c_TW-1:0] c_INIT = c_TW'(TIMER_INIT);

  logic [3:0]      w_op;
  logic [1:0]      w_rs;
  logic [1:0]      w_rt;
  logic [1:0]      w_rd;
  logic            w_rd_rs;
  logic            w_rd_rt;
  logic            w_wr_en;
  logic [1:0]      w_wr_idx;
  logic [NREG-1:0] w_busy;
  logic            w_hazard;
  logic            w_issue;
  logic            w_unused_bits;

  assign w_op          = ifid_ir[15:12];
  assign w_rs          = ifid_ir[11:10];
  assign w_rt          = ifid_ir[9:8];
  assign w_rd          = ifid_ir[7:6];
  assign w_unused_bits = ^ifid_ir[5:0];

  always_comb begin
    w_rd_rs  = 1'b0;
    w_rd_rt  = 1'b0;
    w_wr_en  = 1'b0;
    w_wr_idx = w_rd;
    if (w_op <= 4'd6) begin
      w_rd_rs = 1'b1;
      w_rd_rt = 1'b1;
      w_wr_en = 1'b1;
    end else if (w_op <= 4'd8) begin
      w_rd_rs  = 1'b1;
      w_wr_en  = 1'b1;
      w_wr_idx = w_rt;
    end else if (w_op <= 4'd11) begin
      w_rd_rs = 1'b1;
      w_rd_rt = 1'b1;
    end
  end

  // Register 0 never has a timer, so its busy bit being 0 masks $0 reads.
  assign w_hazard = (w_rd_rs & w_busy[w_rs]) | (w_rd_rt & w_busy[w_rt]);
  assign w_issue  = ~reset & ~branch_taken & ~w_hazard;

  assign w_busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_timer
    logic [c_TW-1:0] r_timer;
    // A timer still at its load value belongs to the producer sitting in
    // ID/EX, which a taken branch squashes.
    always_ff @(negedge clock) begin
      if (reset)
        r_timer <= '0;
      else if (branch_taken && (r_timer == c_INIT))
        r_timer <= '0;
      else if (w_issue && w_wr_en && (w_wr_idx == 2'(r)))
        r_timer <= c_INIT;
      else if (r_timer != '0)
        r_timer <= r_timer - 1'b1;
    end
    assign w_busy[r] = |r_timer;
  end

  assign busy = w_busy;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    if (!reset) begin
      if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
      end else if (w_hazard) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(negedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_hazard && !branch_taken && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (branch_taken && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

`default_nettype wire
